// File: rtl/spi_gpu_pkg.sv
// Shared definitions for the SPI command decoder: opcodes, decoder states and
// status byte layout. The FILL states exist only when SPI_CMD_FILL_EN is defined.
package spi_gpu_pkg;

   localparam logic [7:0] OP_WRITE      = 8'h01;
   localparam logic [7:0] OP_FILL       = 8'h02;
   localparam logic [7:0] OP_SET_CTRL   = 8'h03;
   localparam logic [7:0] OP_CLR_STATUS = 8'h81;

   localparam int ST_BUSY_BIT = 7;
   localparam int ST_OVF_BIT  = 6;
   localparam int ST_ERR_BIT  = 5;

   typedef enum logic [3:0] {
      IDLE,
      ADDR_H,
      ADDR_L,
      WDATA,
      CTRL,
      DISCARD
`ifdef SPI_CMD_FILL_EN
      ,
      CNT_H,
      CNT_L,
      FILL_VAL,
      FILL_RUN
`endif
   } state_t;

   // Status byte returned to the SPI host; low bits reserved as zero.
   function automatic logic [7:0] status_byte(input logic busy, input logic ovf,
                                              input logic err);
      logic [7:0] s;
      s              = 8'h00;
      s[ST_BUSY_BIT] = busy;
      s[ST_OVF_BIT]  = ovf;
      s[ST_ERR_BIT]  = err;
      return s;
   endfunction

endpackage

// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: turns received SPI bytes into framebuffer writes,
// fills and control-register updates. Build option SPI_CMD_FILL_EN adds the
// FILL command (count-driven burst of identical writes); without it opcode
// 0x02 is treated as unknown.
module spi_cmd_decoder
   import spi_gpu_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic              clk_sys,
   input  logic              rst_n,
   input  logic              rx_ready,
   input  logic [7:0]        rx_data,
   input  logic              cs_active,
   output logic [7:0]        tx_data,
   output logic              fb_we,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [7:0]        fb_wdata,
   output logic [7:0]        ctrl_reg
);

   state_t            state;
   logic [7:0]        addr_hi;
   logic [ADDR_W-1:0] addr;
   logic              ovf;
   logic              err_op;
   logic              busy;
   logic [15:0]       addr_full;

   // Address bytes arrive MSB first; the low ADDR_W bits are kept.
   assign addr_full = {addr_hi, rx_data};

`ifdef SPI_CMD_FILL_EN
   logic        op_fill;
   logic [15:0] count;
   logic [7:0]  fill_val;

   assign busy = (state == FILL_RUN);
`else
   assign busy = 1'b0;
`endif

   // Command FSM with registered framebuffer strobe, control register and status.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         addr_hi  <= 8'h00;
         addr     <= '0;
         ovf      <= 1'b0;
         err_op   <= 1'b0;
         fb_we    <= 1'b0;
         fb_addr  <= '0;
         fb_wdata <= 8'h00;
         ctrl_reg <= 8'h00;
         tx_data  <= 8'h00;
`ifdef SPI_CMD_FILL_EN
         op_fill  <= 1'b0;
         count    <= 16'h0000;
         fill_val <= 8'h00;
`endif
      end else begin
         fb_we   <= 1'b0;
         tx_data <= status_byte(busy, ovf, err_op);

         case (state)
            IDLE: begin
               if (rx_ready) begin
                  case (rx_data)
                     OP_WRITE: begin
                        state <= ADDR_H;
`ifdef SPI_CMD_FILL_EN
                        op_fill <= 1'b0;
`endif
                     end
`ifdef SPI_CMD_FILL_EN
                     OP_FILL: begin
                        state   <= ADDR_H;
                        op_fill <= 1'b1;
                     end
`endif
                     OP_SET_CTRL: state <= CTRL;
                     OP_CLR_STATUS: begin
                        ovf    <= 1'b0;
                        err_op <= 1'b0;
                     end
                     default: begin
                        err_op <= 1'b1;
                        state  <= DISCARD;
                     end
                  endcase
               end
            end

            ADDR_H: begin
               if (rx_ready) begin
                  addr_hi <= rx_data;
                  state   <= ADDR_L;
               end
            end

            ADDR_L: begin
               if (rx_ready) begin
                  addr <= addr_full[ADDR_W-1:0];
`ifdef SPI_CMD_FILL_EN
                  state <= op_fill ? CNT_H : WDATA;
`else
                  state <= WDATA;
`endif
               end
            end

            // Streamed write data; address auto-increments and wraps.
            WDATA: begin
               if (rx_ready) begin
                  fb_we    <= 1'b1;
                  fb_addr  <= addr;
                  fb_wdata <= rx_data;
                  addr     <= addr + ADDR_W'(1);
               end
            end

            CTRL: begin
               if (rx_ready) begin
                  ctrl_reg <= rx_data;
                  state    <= IDLE;
               end
            end

            // Rest of the transaction is ignored after an unknown opcode.
            DISCARD: ;

`ifdef SPI_CMD_FILL_EN
            CNT_H: begin
               if (rx_ready) begin
                  count[15:8] <= rx_data;
                  state       <= CNT_L;
               end
            end

            CNT_L: begin
               if (rx_ready) begin
                  count[7:0] <= rx_data;
                  state      <= FILL_VAL;
               end
            end

            // A zero count skips the run entirely.
            FILL_VAL: begin
               if (rx_ready) begin
                  fill_val <= rx_data;
                  state    <= (count == 16'h0000) ? IDLE : FILL_RUN;
               end
            end

            // One write per cycle; incoming bytes cannot be honoured here.
            FILL_RUN: begin
               if (rx_ready) ovf <= 1'b1;
               fb_we    <= 1'b1;
               fb_addr  <= addr;
               fb_wdata <= fill_val;
               addr     <= addr + ADDR_W'(1);
               count    <= count - 16'd1;
               if (count == 16'd1) state <= IDLE;
            end
`endif

            default: state <= IDLE;
         endcase

         // Chip-select release ends any transaction except a running fill;
         // a byte arriving on the same edge has already been acted on above.
         if (!cs_active && !busy) state <= IDLE;
      end
   end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder. Bytes are driven and outputs sampled on
// the falling clock edge; expected values are hand-derived constants.
module tb_spi_cmd_decoder;

   localparam int ADDR_W = 16;

   logic              clk_sys;
   logic              rst_n;
   logic              rx_ready;
   logic [7:0]        rx_data;
   logic              cs_active;
   logic [7:0]        tx_data;
   logic              fb_we;
   logic [ADDR_W-1:0] fb_addr;
   logic [7:0]        fb_wdata;
   logic [7:0]        ctrl_reg;

   int n_vec;
   int n_err;
   int we_cnt;

   spi_cmd_decoder #(.ADDR_W(ADDR_W)) dut (
      .clk_sys   (clk_sys),
      .rst_n     (rst_n),
      .rx_ready  (rx_ready),
      .rx_data   (rx_data),
      .cs_active (cs_active),
      .tx_data   (tx_data),
      .fb_we     (fb_we),
      .fb_addr   (fb_addr),
      .fb_wdata  (fb_wdata),
      .ctrl_reg  (ctrl_reg)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   // Count framebuffer strobes seen at the sampling edge.
   always @(negedge clk_sys) if (fb_we === 1'b1) we_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One rx_ready pulse; returns at the falling edge after it was consumed.
   task automatic send(input logic [7:0] b);
      @(negedge clk_sys);
      rx_ready = 1'b1;
      rx_data  = b;
      @(negedge clk_sys);
      rx_ready = 1'b0;
   endtask

   task automatic cs_on();
      @(negedge clk_sys);
      cs_active = 1'b1;
   endtask

   task automatic cs_off();
      @(negedge clk_sys);
      cs_active = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   int base;

   initial begin
      n_vec = 0; n_err = 0; we_cnt = 0;
      rst_n = 1'b0; rx_ready = 1'b0; rx_data = 8'h00; cs_active = 1'b0;
      idle(2);
      check("rst_tx",   32'(tx_data),  32'h00);
      check("rst_we",   32'(fb_we),    32'h0);
      check("rst_addr", 32'(fb_addr),  32'h0);
      check("rst_wdat", 32'(fb_wdata), 32'h00);
      check("rst_ctrl", 32'(ctrl_reg), 32'h00);
      rst_n = 1'b1;
      idle(2);

      // WRITE 01 12 34 AA BB
      cs_on();
      send(8'h01); send(8'h12); send(8'h34);
      send(8'hAA);
      check("wr0_we",   32'(fb_we),    32'h1);
      check("wr0_addr", 32'(fb_addr),  32'h1234);
      check("wr0_data", 32'(fb_wdata), 32'hAA);
      @(negedge clk_sys);
      check("wr0_pulse", 32'(fb_we),   32'h0);
      send(8'hBB);
      check("wr1_we",   32'(fb_we),    32'h1);
      check("wr1_addr", 32'(fb_addr),  32'h1235);
      check("wr1_data", 32'(fb_wdata), 32'hBB);
      cs_off();

      // Address wrap 01 FF FF 11 22
      cs_on();
      send(8'h01); send(8'hFF); send(8'hFF);
      send(8'h11);
      check("wrap0_addr", 32'(fb_addr),  32'hFFFF);
      check("wrap0_data", 32'(fb_wdata), 32'h11);
      send(8'h22);
      check("wrap1_addr", 32'(fb_addr),  32'h0000);
      check("wrap1_data", 32'(fb_wdata), 32'h22);
      cs_off();

      // Unknown opcode discards the rest of the transaction
      cs_on();
      send(8'h7E); send(8'h03); send(8'h55);
      cs_off();
      idle(2);
      check("unk_ctrl", 32'(ctrl_reg), 32'h00);
      check("unk_tx",   32'(tx_data),  32'h20);
      cs_on();
      send(8'h03); send(8'h55);
      check("ctrl_55",  32'(ctrl_reg), 32'h55);
      cs_off();

      // CLEAR_STATUS
      cs_on();
      send(8'h81);
      idle(2);
      check("clr_tx", 32'(tx_data), 32'h00);
      cs_off();

      // Chip-select drop mid-command returns to IDLE
      base = we_cnt;
      cs_on();
      send(8'h01); send(8'h12);
      cs_off();
      cs_on();
      send(8'h03); send(8'hA5);
      idle(2);
      check("csdrop_ctrl", 32'(ctrl_reg), 32'hA5);
      check("csdrop_nowe", 32'(we_cnt - base), 32'd0);
      cs_off();

`ifdef SPI_CMD_FILL_EN
      // FILL 02 00 10 00 04 5A, one extra byte during the run
      cs_on();
      send(8'h02); send(8'h00); send(8'h10); send(8'h00); send(8'h04);
      send(8'h5A);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_sys);
         check("fill_we",   32'(fb_we),      32'h1);
         check("fill_addr", 32'(fb_addr),    32'h10 + 32'(i));
         check("fill_data", 32'(fb_wdata),   32'h5A);
         check("fill_busy", 32'(tx_data[7]), 32'h1);
         rx_ready = (i == 0);
         rx_data  = 8'h99;
      end
      @(negedge clk_sys);
      check("fill_end_we", 32'(fb_we), 32'h0);
      idle(2);
      check("fill_ovf_tx", 32'(tx_data), 32'h40);
      cs_off();
      cs_on();
      send(8'h81);
      idle(2);
      check("fill_clr_tx", 32'(tx_data), 32'h00);
      cs_off();

      // Zero count performs no writes
      base = we_cnt;
      cs_on();
      send(8'h02); send(8'h00); send(8'h20); send(8'h00); send(8'h00);
      send(8'h77);
      idle(4);
      check("fill0_nowe", 32'(we_cnt - base), 32'd0);
      cs_off();

      // Reset in the middle of a 100-write fill
      cs_on();
      send(8'h02); send(8'h00); send(8'h00); send(8'h00); send(8'h64);
      send(8'h33);
      idle(5);
      rst_n = 1'b0;
      #1;
      check("rstfill_we",   32'(fb_we),    32'h0);
      check("rstfill_addr", 32'(fb_addr),  32'h0);
      check("rstfill_data", 32'(fb_wdata), 32'h00);
      check("rstfill_tx",   32'(tx_data),  32'h00);
      check("rstfill_ctrl", 32'(ctrl_reg), 32'h00);
      cs_active = 1'b0;
      idle(2);
      rst_n = 1'b1;
      base = we_cnt;
      idle(6);
      check("rstfill_stop", 32'(we_cnt - base), 32'd0);
`else
      // FILL absent: 0x02 behaves as an unknown opcode
      base = we_cnt;
      cs_on();
      send(8'h02); send(8'h00); send(8'h10); send(8'h00); send(8'h04);
      send(8'h5A);
      idle(3);
      check("nofill_tx",   32'(tx_data), 32'h20);
      check("nofill_nowe", 32'(we_cnt - base), 32'd0);
      cs_off();
      cs_on();
      send(8'h81);
      idle(2);
      check("nofill_clr", 32'(tx_data), 32'h00);
      cs_off();

      // Reset state reasserted mid-transaction
      cs_on();
      send(8'h03);
      rst_n = 1'b0;
      #1;
      check("rst2_ctrl", 32'(ctrl_reg), 32'h00);
      check("rst2_tx",   32'(tx_data),  32'h00);
      cs_active = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(2);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
